// File: rtl/axil_cmd_master.sv
// AXI-Lite initiator: turns one command word into one AXI-Lite write or read
// and returns the slave's response on a registered response port.
module axil_cmd_master #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 4,
  parameter bit          OPT_LOWPOWER     = 1'b0
) (
  input  logic                        m_axi_aclk,
  input  logic                        m_axi_aresetn,

  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                 cmd_wdata,
  input  logic [3:0]                  cmd_wstrb,

  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [1:0]                  rsp_resp,
  output logic [31:0]                 rsp_rdata,

  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,

  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [31:0]                 m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,

  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,

  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,

  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [31:0]                 m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp
);

  localparam int unsigned AW = C_AXI_ADDR_WIDTH;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_B = 3'd2,
    RD     = 3'd3,
    WAIT_R = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_al;
  logic          aw_fin;
  logic          w_fin;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // Word-aligned command address.
  assign addr_al = {cmd_addr[AW-1:2], 2'b00};

  // A channel is finished once its valid has dropped or it handshakes now.
  assign aw_fin = !m_axi_awvalid || m_axi_awready;
  assign w_fin  = !m_axi_wvalid  || m_axi_wready;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_resp      <= 2'b00;
      rsp_rdata     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              state         <= WR;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_awaddr  <= addr_al;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= SW'(cmd_wstrb);
            end else begin
              state         <= RD;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= addr_al;
            end
          end
        end

        WR: begin
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            if (OPT_LOWPOWER) m_axi_awaddr <= '0;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
            if (OPT_LOWPOWER) m_axi_wdata <= '0;
          end
          if (aw_fin && w_fin) begin
            state        <= WAIT_B;
            m_axi_bready <= 1'b1;
          end
        end

        WAIT_B: begin
          if (m_axi_bvalid) begin
            state        <= RESP;
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b1;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
          end
        end

        RD: begin
          if (m_axi_arready) begin
            state         <= WAIT_R;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            if (OPT_LOWPOWER) m_axi_araddr <= '0;
          end
        end

        WAIT_R: begin
          if (m_axi_rvalid) begin
            state        <= RESP;
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
          end
        end

        RESP: begin
          // cmd_ready rises only after the response handshake edge.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            if (OPT_LOWPOWER) rsp_rdata <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master: AXI-Lite RAM slave with random stalls,
// a word-array reference model and bus-protocol monitors.
module tb_axil_cmd_master;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [1:0]    rsp_resp;
  logic [31:0]   rsp_rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axil_cmd_master #(.C_AXI_ADDR_WIDTH(AW), .OPT_LOWPOWER(1'b0)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model and slave storage (independent copies).
  logic [31:0] model [4];
  logic [31:0] smem  [4];

  int         aw_fix = -1, w_fix = -1, b_fix = -1, ar_fix = -1, r_fix = -1;
  bit         hold_w = 1'b0;
  logic [1:0] cur_resp = 2'b00;

  function automatic int pick(input int fix);
    if (fix < 0) return int'($urandom_range(3, 0));
    return fix;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Monitor state, sampled on the falling edge.
  bit            hs_aw, hs_w, hs_b, hs_ar, hs_r;
  int            n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_ar_hs = 0, n_r_hs = 0;
  logic [AW-1:0] obs_awaddr, obs_araddr;
  logic [31:0]   obs_wdata;
  logic [3:0]    obs_wstrb;
  int            viol_stab = 0, viol_bready = 0;
  bit            aw_got, w_got, ar_got;

  initial begin : monitor
    bit p_aw, p_w, p_ar, p_rsp;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [35:0]   p_wpay;
    logic [34:0]   p_rpay;
    p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
    p_awaddr = '0; p_araddr = '0; p_wpay = '0; p_rpay = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
      end else begin
        hs_aw = awvalid && awready;
        hs_w  = wvalid && wready;
        hs_b  = bvalid && bready;
        hs_ar = arvalid && arready;
        hs_r  = rvalid && rready;
        if (hs_aw) begin n_aw_hs++; obs_awaddr = awaddr; end
        if (hs_w)  begin n_w_hs++; obs_wdata = wdata; obs_wstrb = wstrb; end
        if (hs_b)  n_b_hs++;
        if (hs_ar) begin n_ar_hs++; obs_araddr = araddr; end
        if (hs_r)  n_r_hs++;
        if (bready && !(aw_got && w_got)) viol_bready++;
        if (p_aw && (!awvalid || awaddr !== p_awaddr)) viol_stab++;
        if (p_w && (!wvalid || {wdata, wstrb} !== p_wpay)) viol_stab++;
        if (p_ar && (!arvalid || araddr !== p_araddr)) viol_stab++;
        if (p_rsp && (!rsp_valid || {rsp_write, rsp_resp, rsp_rdata} !== p_rpay)) viol_stab++;
        p_aw = awvalid && !awready;  p_awaddr = awaddr;
        p_w  = wvalid && !wready;    p_wpay   = {wdata, wstrb};
        p_ar = arvalid && !arready;  p_araddr = araddr;
        p_rsp = rsp_valid && !rsp_ready;
        p_rpay = {rsp_write, rsp_resp, rsp_rdata};
      end
    end
  end

  // AXI-Lite RAM slave with randomized ready/response latencies.
  initial begin : slave
    bit aw_pend, w_pend, ar_pend, b_pend, r_pend;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      end else begin
        if (hs_aw) begin aw_pend = 0; aw_got = 1; end
        if (hs_w)  begin w_pend = 0; w_got = 1; end
        if (hs_ar) begin ar_pend = 0; ar_got = 1; end
        if (hs_b)  begin bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0; end
        if (hs_r)  begin rvalid = 0; r_pend = 0; ar_got = 0; end

        if (awvalid && !aw_pend) begin aw_pend = 1; aw_cnt = pick(aw_fix); end
        awready = aw_pend && aw_cnt == 0;
        if (aw_pend && aw_cnt > 0) aw_cnt--;

        if (wvalid && !w_pend) begin w_pend = 1; w_cnt = pick(w_fix); end
        wready = w_pend && w_cnt == 0 && !hold_w;
        if (w_pend && w_cnt > 0 && !hold_w) w_cnt--;

        if (arvalid && !ar_pend) begin ar_pend = 1; ar_cnt = pick(ar_fix); end
        arready = ar_pend && ar_cnt == 0;
        if (ar_pend && ar_cnt > 0) ar_cnt--;

        if (aw_got && w_got && !b_pend) begin
          b_pend = 1; b_cnt = pick(b_fix);
          if (cur_resp == 2'b00)
            smem[obs_awaddr[3:2]] = merge(smem[obs_awaddr[3:2]], obs_wdata, obs_wstrb);
        end
        if (b_pend && !bvalid) begin
          if (b_cnt == 0) begin bvalid = 1; bresp = cur_resp; end
          else b_cnt--;
        end

        if (ar_got && !r_pend) begin r_pend = 1; r_cnt = pick(r_fix); end
        if (r_pend && !rvalid) begin
          if (r_cnt == 0) begin rvalid = 1; rdata = smem[obs_araddr[3:2]]; rresp = cur_resp; end
          else r_cnt--;
        end
      end
    end
  end

  // One complete command; wait_cyc reports idle cycles before acceptance.
  task automatic do_cmd(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] resp, input int rdly,
                        input bit poke, output int wait_cyc);
    int b_aw, b_w, b_b, b_ar, b_r, t, busy_bad, hold_bad;
    logic [31:0] exp_rd;
    cur_resp = resp;
    b_aw = n_aw_hs; b_w = n_w_hs; b_b = n_b_hs; b_ar = n_ar_hs; b_r = n_r_hs;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    t = 0;
    while (!cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
    wait_cyc = t;
    check("cmd_ready_before_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    check("lat_awvalid", awvalid, wr);
    check("lat_wvalid", wvalid, wr);
    check("lat_arvalid", arvalid, !wr);
    busy_bad = 0; t = 0;
    while (!rsp_valid && t < 200) begin
      if (cmd_ready) busy_bad++;
      @(posedge clk); #1; t++;
    end
    check("rsp_valid_timeout", rsp_valid, 1'b1);
    check("busy_cmd_ready", busy_bad, 0);
    exp_rd = wr ? 32'h0 : model[addr[3:2]];
    check("rsp_write", rsp_write, wr);
    check("rsp_resp", rsp_resp, resp);
    check("rsp_rdata", rsp_rdata, exp_rd);
    hold_bad = 0;
    for (int i = 0; i < rdly; i++) begin
      if (poke) begin cmd_valid = 1; cmd_write = $urandom; cmd_addr = $urandom; end
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || rsp_resp !== resp || rsp_rdata !== exp_rd) hold_bad++;
    end
    cmd_valid = 0;
    if (rdly > 0) check("rsp_hold", hold_bad, 0);
    rsp_ready = 1;
    check("cmd_ready_at_rsp_hs", cmd_ready, 1'b0);
    @(posedge clk); #1;
    rsp_ready = 0;
    check("rsp_valid_after_hs", rsp_valid, 1'b0);
    check("cmd_ready_after_hs", cmd_ready, 1'b1);
    if (wr) begin
      check("aw_hs_count", n_aw_hs - b_aw, 1);
      check("w_hs_count", n_w_hs - b_w, 1);
      check("b_hs_count", n_b_hs - b_b, 1);
      check("awaddr", obs_awaddr, {addr[3:2], 2'b00});
      check("wdata", obs_wdata, data);
      check("wstrb", obs_wstrb, strb);
      if (resp == 2'b00) model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
    end else begin
      check("ar_hs_count", n_ar_hs - b_ar, 1);
      check("r_hs_count", n_r_hs - b_r, 1);
      check("aw_hs_on_read", n_aw_hs - b_aw, 0);
      check("araddr", obs_araddr, {addr[3:2], 2'b00});
    end
  endtask

  initial begin : main
    int wc, t, b_aw;
    logic [1:0] rr;
    for (int i = 0; i < 4; i++) begin model[i] = '0; smem[i] = '0; end
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 36'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("prot", {awprot, arprot}, 6'h0);

    aw_fix = 0; w_fix = 0; b_fix = 0; ar_fix = 0; r_fix = 0;
    do_cmd(1, 4'h4, 32'h0000_0001, 4'hF, 2'b00, 0, 0, wc);
    aw_fix = 4; w_fix = 1;
    do_cmd(1, 4'h7, 32'hA5A5_A5A5, 4'h3, 2'b00, 0, 0, wc);
    aw_fix = 0; w_fix = 0;
    do_cmd(1, 4'hC, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, wc);
    ar_fix = 2; r_fix = 1;
    do_cmd(0, 4'hC, 32'h0, 4'h0, 2'b00, 0, 0, wc);
    check("read_deadbeef_model", model[3], 32'hDEAD_BEEF);
    ar_fix = 0; r_fix = 0;
    do_cmd(0, 4'h4, 32'h0, 4'h0, 2'b10, 5, 1, wc);
    do_cmd(1, 4'h0, 32'h0000_0001, 4'hF, 2'b00, 0, 0, wc);
    do_cmd(0, 4'h0, 32'h0, 4'h0, 2'b00, 0, 0, wc);
    check("b2b_accept_wait", wc, 0);
    do_cmd(1, 4'h8, 32'h1234_5678, 4'hF, 2'b11, 1, 0, wc);

    // Reset between AW and W handshakes.
    aw_fix = 0; hold_w = 1; cur_resp = 2'b00; b_aw = n_aw_hs;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 0;
    t = 0;
    while (n_aw_hs == b_aw && t < 50) begin @(posedge clk); #1; t++; end
    check("abort_aw_done", awvalid, 1'b0);
    check("abort_w_pending", wvalid, 1'b1);
    #2 rst_n = 0;
    #1;
    check("abort_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    hold_w = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("abort_cmd_ready", cmd_ready, 1'b1);
    check("abort_no_rsp", rsp_valid, 1'b0);
    ar_fix = -1; r_fix = -1;
    do_cmd(0, 4'h8, 32'h0, 4'h0, 2'b00, 0, 0, wc);

    aw_fix = -1; w_fix = -1; b_fix = -1;
    for (int n = 0; n < 40; n++) begin
      rr = ($urandom_range(3, 0) == 0) ? (($urandom & 1) ? 2'b10 : 2'b11) : 2'b00;
      do_cmd(1'($urandom), 4'($urandom), $urandom, 4'($urandom), rr,
             int'($urandom_range(3, 0)), 1'($urandom), wc);
    end

    check("valid_stability", viol_stab, 0);
    check("bready_outside_wait_b", viol_bready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI-Lite initiator that turns single-word commands into AXI-Lite write or read transactions on a 32-bit bus.
- Drives the memory/LED register slaves (4-word LED RAM and similar) from firmware-side or test-sequencer logic.
- Exactly one transaction is in flight at a time; its result comes back on a registered response port.

Parameters:
- C_AXI_ADDR_WIDTH, 4, AXI byte-address width; data width is a fixed localparam of 32 (strobe width 4).
- OPT_LOWPOWER, 0, when 1: m_axi_wdata, m_axi_awaddr, m_axi_araddr and rsp_rdata are forced to 0 whenever their valid is low.

Ports:
- m_axi_aclk  in  1  single clock for all logic.
- m_axi_aresetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_AXI_ADDR_WIDTH  byte address; the low 2 bits are ignored.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_write  out  1  echoes cmd_write.
- rsp_resp  out  2  BRESP or RRESP as returned by the slave.
- rsp_rdata  out  32  RDATA for reads; 0 for writes.
- m_axi_awvalid/awready/awaddr[C_AXI_ADDR_WIDTH]/awprot[3]  AW channel (awprot is out, constant 3'b000).
- m_axi_wvalid/wready/wdata[32]/wstrb[4]  W channel.
- m_axi_bvalid/bready/bresp[2]  B channel.
- m_axi_arvalid/arready/araddr[C_AXI_ADDR_WIDTH]/arprot[3]  AR channel (arprot is out, constant 3'b000).
- m_axi_rvalid/rready/rdata[32]/rresp[2]  R channel.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State returns to IDLE.
  - Every valid output, m_axi_bready and m_axi_rready are 0.
  - rsp_* outputs are 0.
  - cmd_ready is 1 after reset release.
- An assertion of reset mid-transaction aborts it immediately. No response is produced; the slave side must be reset together with this block.
- FSM states: IDLE, WR (AW/W in flight), WAIT_B, RD (AR in flight), WAIT_R, RESP.
- IDLE:
  - cmd_ready=1. A command is accepted when cmd_valid && cmd_ready.
  - On acceptance, addr, data and strb are registered with addr[1:0] forced to 0.
  - Next state is WR if cmd_write, else RD.
  - The AW/W or AR valids go high on the cycle after acceptance (one cycle of latency).
- WR:
  - m_axi_awvalid and m_axi_wvalid are asserted independently.
  - Each valid drops on the cycle after its own handshake and never re-asserts.
  - AW-first, W-first and simultaneous handshakes must all work.
  - When both handshakes are done, go to WAIT_B. If the last handshake happens in the current cycle, WAIT_B is entered on the next edge.
- WAIT_B:
  - m_axi_bready=1 (combinational on state).
  - On bvalid, capture bresp, set rsp_write=1 and rsp_rdata=0, then go to RESP.
  - A bvalid seen before AW and W are both complete is ignored; bready is 0 outside WAIT_B.
- RD:
  - m_axi_arvalid=1; araddr and arvalid stay stable until arready.
  - On the handshake, go to WAIT_R.
- WAIT_R:
  - m_axi_rready=1.
  - On rvalid, capture rdata and rresp, set rsp_write=0, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. cmd_ready rises on the next cycle; no command is accepted in the same cycle as the response handshake.
- No valid output changes or drops before its ready, per AXI.
- Non-OKAY responses (SLVERR 2'b10, DECERR 2'b11) are passed through unchanged; the block takes no other action on them.
- Throughput: at most one command per 4 cycles when the slave and consumer are zero-wait.
- No transaction counters or timeouts; a slave that never responds stalls the block until reset.

Test Plan:
- Write addr 0x4, data 0x00000001, strb 0xF; slave awready/wready immediate, bvalid one cycle later with OKAY -> awaddr=0x4, wdata=0x1, then rsp_valid with rsp_write=1, rsp_resp=00, rsp_rdata=0; the mem slave then drives leds=4'b0010.
- Write addr 0x7, data 0xA5A5A5A5, strb 0x3; wready 1 cycle after valid, awready 4 cycles after valid -> awaddr=0x4, exactly one AW and one W handshake, bready high only in WAIT_B, a single response.
- Read addr 0xC; arready delayed 2 cycles, rvalid with rdata=0xDEADBEEF and rresp=00 -> rsp_rdata=0xDEADBEEF, rsp_write=0; cmd_ready low from acceptance until the cycle after the response handshake.
- Read with rresp=2'b10 and rsp_ready held low 5 cycles -> rsp_valid held high with stable rsp_resp=10 for all 6 cycles; a new cmd_valid during that window is not accepted.
- Back-to-back: write 0x1 to addr 0x0, then read addr 0x0 against the LED-RAM slave -> read returns 0x00000001; the second command is accepted exactly 1 cycle after the first response handshake.
- Assert m_axi_aresetn low during WR after the AW handshake but before the W handshake -> all valids and bready drop in the same cycle (asynchronous), no rsp_valid; after release cmd_ready=1 and a new read completes normally.
